// File: rtl/soc_io_ports.sv
// Memory-mapped I/O page for the RISC-V SOC: LED register, 8N1 UART transmitter,
// status word and free-running cycle counter, all read back with one cycle of latency.
module soc_io_ports #(
  parameter int CLK_FREQ_HZ = 25000000,
  parameter int BAUD        = 115200,
  parameter int NUM_LEDS    = 8,
  parameter int IO_ADDR_BIT = 22
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wdata,
  input  logic [3:0]          mem_wmask,
  input  logic                mem_rstrb,
  output logic [31:0]         io_rdata,
  output logic [NUM_LEDS-1:0] leds,
  output logic                uart_txd,
  output logic                uart_busy
);

  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  uart_state_t       r_state, w_state_next;
  logic [CW-1:0]     r_baud, w_baud_next;
  logic [2:0]        r_bit, w_bit_next;
  logic [7:0]        r_shift, w_shift_next;
  logic              r_txd, w_txd_next;
  logic              r_busy;
  logic [NUM_LEDS-1:0] r_leds;
  logic [31:0]       r_rdata, r_cycles;

  logic        w_sel, w_led_wr, w_uart_wr, w_baud_end;
  logic [1:0]  w_word;
  logic [31:0] w_leds_wide, w_read_val;
  logic        w_unused;

  assign w_sel      = mem_addr[IO_ADDR_BIT];
  assign w_word     = mem_addr[3:2];
  assign w_led_wr   = w_sel && (w_word == 2'd0) && (|mem_wmask);
  assign w_uart_wr  = w_sel && (w_word == 2'd1) && mem_wmask[0];
  assign w_baud_end = (r_baud == BAUD_LAST);

  // Address/data bits outside the decoded fields are deliberately ignored.
  assign w_unused = &{1'b0, mem_addr, mem_wdata, w_leds_wide};

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_leds_wide = 32'(r_leds);
    for (int b = 0; b < 4; b++) begin
      if (mem_wmask[b]) w_leds_wide[8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  always_comb begin
    w_read_val = '0;
    unique case (w_word)
      2'd0:    w_read_val = 32'(r_leds);
      2'd1:    w_read_val = '0;
      2'd2:    w_read_val = {31'd0, r_busy};
      default: w_read_val = r_cycles;
    endcase
  end

  // Next-state logic; the baud counter restarts at every state or bit change.
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    unique case (r_state)
      S_IDLE: begin
        if (w_uart_wr) begin
          w_state_next = S_START;
          w_baud_next  = '0;
          w_shift_next = mem_wdata[7:0];
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_state_next = S_DATA;
          w_baud_next  = '0;
          w_bit_next   = '0;
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_next  = '0;
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) w_state_next = S_STOP;
          else               w_bit_next   = r_bit + 1'b1;
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      default: begin
        if (w_baud_end) begin
          w_state_next = S_IDLE;
          w_baud_next  = '0;
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
    endcase

    // txd is registered from the next state, so the line changes on the same edge as the FSM.
    unique case (w_state_next)
      S_START: w_txd_next = 1'b0;
      S_DATA:  w_txd_next = w_shift_next[0];
      default: w_txd_next = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_txd    <= 1'b1;
      r_busy   <= 1'b0;
      r_leds   <= '0;
      r_rdata  <= '0;
      r_cycles <= '0;
    end else begin
      r_state  <= w_state_next;
      r_baud   <= w_baud_next;
      r_bit    <= w_bit_next;
      r_shift  <= w_shift_next;
      r_txd    <= w_txd_next;
      r_busy   <= (w_state_next != S_IDLE);
      r_cycles <= r_cycles + 32'd1;
      if (w_led_wr) r_leds <= w_leds_wide[NUM_LEDS-1:0];
      if (w_sel && mem_rstrb) r_rdata <= w_read_val;
    end
  end

  assign io_rdata  = r_rdata;
  assign leds      = r_leds;
  assign uart_txd  = r_txd;
  assign uart_busy = r_busy;

endmodule

// File: tb/tb_soc_io_ports.sv
// Directed bench for soc_io_ports at DIV=4: register map, UART framing, overrun,
// back-to-back frames, reset abort and cycle-counter wrap.
module tb_soc_io_ports;

  localparam logic [31:0] A_LEDS   = 32'h0040_0000;
  localparam logic [31:0] A_UART   = 32'h0040_0004;
  localparam logic [31:0] A_STATUS = 32'h0040_0008;
  localparam logic [31:0] A_CYCLES = 32'h0040_000C;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] io_rdata;
  logic [7:0]  leds;
  logic        uart_txd;
  logic        uart_busy;

  int n_checks = 0;
  int n_pass   = 0;

  soc_io_ports #(
    .CLK_FREQ_HZ(1000),
    .BAUD       (250),
    .NUM_LEDS   (8),
    .IO_ADDR_BIT(22)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb),
    .io_rdata (io_rdata),
    .leds     (leds),
    .uart_txd (uart_txd),
    .uart_busy(uart_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a negedge: presents one bus cycle, returns at the next negedge with the bus idle.
  task automatic drive(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask, input logic rstrb);
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wmask = wmask;
    mem_rstrb = rstrb;
    @(negedge clk);
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    mem_rstrb = 1'b0;
  endtask

  task automatic idle();
    drive(32'h0, 32'h0, 4'b0000, 1'b0);
  endtask

  // Entered at the negedge after the accepting write edge; returns at sample 40 (frame over).
  task automatic check_frame(input string tag, input logic [7:0] data,
                             input int status_at, input int overrun_at);
    logic [9:0]  exp_bits;
    logic [39:0] got_line;
    logic [39:0] exp_line;
    int          busy_n;
    exp_bits = {1'b1, data, 1'b0};
    busy_n   = 0;
    for (int i = 0; i < 40; i++) begin
      got_line[i] = uart_txd;
      exp_line[i] = exp_bits[i/4];
      if (uart_busy) busy_n++;
      if (i == status_at) begin
        drive(A_STATUS, 32'h0, 4'b0000, 1'b1);
        check({tag, " status_mid"}, 64'(io_rdata), 64'd1);
      end else if (i == overrun_at) begin
        drive(A_UART, 32'h0000_000F, 4'b0001, 1'b0);
      end else begin
        idle();
      end
    end
    check({tag, " txd_line"}, 64'(got_line), 64'(exp_line));
    check({tag, " busy_cycles"}, 64'(busy_n), 64'd40);
    check({tag, " busy_end"}, 64'(uart_busy), 64'd0);
    check({tag, " txd_end"}, 64'(uart_txd), 64'd1);
  endtask

  initial begin
    logic [31:0] c0;
    int          busy_n;

    rst       = 1'b1;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    mem_rstrb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst leds", 64'(leds), 64'h0);
    check("rst txd", 64'(uart_txd), 64'h1);
    check("rst busy", 64'(uart_busy), 64'h0);
    check("rst rdata", 64'(io_rdata), 64'h0);
    rst = 1'b0;

    // LED register and read path
    drive(A_LEDS, 32'h0000_00A5, 4'b0001, 1'b0);
    check("led write", 64'(leds), 64'hA5);
    check("rdata before read", 64'(io_rdata), 64'h0);
    drive(A_LEDS, 32'h0, 4'b0000, 1'b1);
    check("led read", 64'(io_rdata), 64'hA5);
    drive(A_LEDS, 32'h0000_FF00, 4'b0001, 1'b0);
    check("led lane0 only", 64'(leds), 64'h00);
    drive(A_LEDS, 32'h0000_003C, 4'b1111, 1'b0);
    check("led full mask", 64'(leds), 64'h3C);
    drive(A_LEDS, 32'h0000_0011, 4'b0010, 1'b0);
    check("led lane1 discarded", 64'(leds), 64'h3C);
    drive(32'h0000_0000, 32'h0000_00FF, 4'b1111, 1'b0);
    check("unsel led write", 64'(leds), 64'h3C);
    drive(32'h0000_0008, 32'h0, 4'b0000, 1'b1);
    check("unsel read holds", 64'(io_rdata), 64'hA5);
    drive(A_LEDS, 32'h0000_0077, 4'b0001, 1'b1);
    check("rw same cycle rdata", 64'(io_rdata), 64'h3C);
    check("rw same cycle leds", 64'(leds), 64'h77);
    drive(A_UART, 32'h0, 4'b0000, 1'b1);
    check("uart_data reads 0", 64'(io_rdata), 64'h0);
    drive(A_STATUS, 32'hFFFF_FFFF, 4'b1111, 1'b0);
    check("status write ignored", 64'(leds), 64'h77);
    drive(A_STATUS, 32'h0, 4'b0000, 1'b1);
    check("status idle", 64'(io_rdata), 64'h0);

    // UART writes that must not start a frame
    drive(A_UART, 32'h0000_0055, 4'b0010, 1'b0);
    check("uart wmask0 clear", 64'(uart_busy), 64'h0);
    drive(32'h0000_0004, 32'h0000_0055, 4'b0001, 1'b0);
    check("uart unselected", 64'(uart_busy), 64'h0);
    check("uart unselected txd", 64'(uart_txd), 64'h1);

    // Frame 0x55 with a mid-frame status read and an overrun write at frame cycle 10
    drive(A_UART, 32'h0000_0055, 4'b0001, 1'b0);
    check_frame("frame55", 8'h55, 5, 9);
    drive(A_STATUS, 32'h0, 4'b0000, 1'b1);
    check("status after frame", 64'(io_rdata), 64'h0);
    busy_n = 0;
    for (int i = 0; i < 12; i++) begin
      if (uart_busy || !uart_txd) busy_n++;
      idle();
    end
    check("no second frame", 64'(busy_n), 64'd0);

    // Back-to-back frames: second write lands on the first cycle busy is low
    drive(A_UART, 32'h0000_000F, 4'b0001, 1'b0);
    check_frame("frame0F", 8'h0F, -1, -1);
    drive(A_UART, 32'h0000_000F, 4'b0001, 1'b0);
    check_frame("b2b", 8'h0F, -1, -1);

    // Cycle counter distances and wrap
    drive(A_CYCLES, 32'h0, 4'b0000, 1'b1);
    c0 = io_rdata;
    drive(A_CYCLES, 32'h0, 4'b0000, 1'b1);
    check("cycles consecutive", 64'(io_rdata - c0), 64'd1);
    c0 = io_rdata;
    for (int i = 0; i < 4; i++) idle();
    drive(A_CYCLES, 32'h0, 4'b0000, 1'b1);
    check("cycles distance 5", 64'(io_rdata - c0), 64'd5);
    drive(A_CYCLES, 32'hFFFF_FFFF, 4'b1111, 1'b1);
    check("cycles write ignored", 64'(io_rdata - c0), 64'd6);

    force dut.r_cycles = 32'hFFFF_FFFF;
    #1;
    release dut.r_cycles;
    drive(A_CYCLES, 32'h0, 4'b0000, 1'b1);
    check("cycles at max", 64'(io_rdata), 64'hFFFF_FFFF);
    drive(A_CYCLES, 32'h0, 4'b0000, 1'b1);
    check("cycles wrapped", 64'(io_rdata), 64'h0);

    // Reset in the middle of an all-zero frame
    drive(A_LEDS, 32'h0000_005A, 4'b0001, 1'b0);
    drive(A_UART, 32'h0000_0000, 4'b0001, 1'b0);
    for (int i = 0; i < 6; i++) idle();
    drive(A_CYCLES, 32'h0, 4'b0000, 1'b1);
    check("pre-reset txd low", 64'(uart_txd), 64'h0);
    check("pre-reset busy", 64'(uart_busy), 64'h1);
    rst = 1'b1;
    idle();
    check("mid rst txd", 64'(uart_txd), 64'h1);
    check("mid rst busy", 64'(uart_busy), 64'h0);
    check("mid rst leds", 64'(leds), 64'h0);
    check("mid rst rdata", 64'(io_rdata), 64'h0);
    idle();
    rst = 1'b0;
    drive(A_CYCLES, 32'h0, 4'b0000, 1'b1);
    check("cycles restart", 64'(io_rdata), 64'h0);
    drive(A_CYCLES, 32'h0, 4'b0000, 1'b1);
    check("cycles after restart", 64'(io_rdata), 64'h1);
    check("post rst txd", 64'(uart_txd), 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
